// File: rtl/valve_air_sched.sv
// ---------------------------------------------------------------------------
// valve_air_sched
//
// Shares one compressed-air supply between two ejector valves. Fire requests
// (single-cycle pulses) are queued as saturating 3-bit pending counts. The
// scheduler grants the air round-robin when both valves are waiting. It holds
// the granted valve open for PULSE_TICKS ticks. It then waits RECOVER_TICKS
// ticks so the air pressure can recover before the next grant. One tick is
// TICK_DIV clock cycles (100 us at 50 MHz with the default value).
//
// Optional feature macro: VALVE_SCHED_STATS_EN
//   defined   -> fire_cnt1/fire_cnt2 count grants per valve (16-bit, wrapping)
//   undefined -> fire_cnt1/fire_cnt2 are tied to 0, no counter registers
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   enable      1 = new grants allowed (a running pulse/recovery always completes)
//   req1, req2  fire requests, one count per cycle high
//   valve1_cmd  registered valve 1 drive
//   valve2_cmd  registered valve 2 drive
//   busy        high while firing or recovering
//   pend1       pending count for valve 1
//   pend2       pending count for valve 2
//   overflow    sticky; a request arrived while its count was at PEND_MAX
//   fire_cnt1   valve 1 firing count (zero when stats are disabled)
//   fire_cnt2   valve 2 firing count (zero when stats are disabled)
// ---------------------------------------------------------------------------
module valve_air_sched #(
    parameter int TICK_DIV      = 5000,
    parameter int PULSE_TICKS   = 300,
    parameter int RECOVER_TICKS = 200,
    parameter int PEND_MAX      = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        req1,
    input  logic        req2,
    output logic        valve1_cmd,
    output logic        valve2_cmd,
    output logic        busy,
    output logic [2:0]  pend1,
    output logic [2:0]  pend2,
    output logic        overflow,
    output logic [15:0] fire_cnt1,
    output logic [15:0] fire_cnt2
);

    typedef enum logic [1:0] {IDLE, FIRE, RECOVER} state_t;

    localparam logic [12:0] PRESC_LOAD   = 13'(TICK_DIV - 1);
    localparam logic [9:0]  PULSE_LOAD   = 10'(PULSE_TICKS);
    localparam logic [9:0]  RECOVER_LOAD = 10'(RECOVER_TICKS);
    localparam logic [2:0]  PEND_LIM     = 3'(PEND_MAX);

    state_t      state, state_next;
    logic [12:0] presc;
    logic [9:0]  timer;
    logic        rr_ptr;        // 0 = valve 1 wins the next contested grant
    logic        grant1, grant2;
    logic        both_pending;
    logic        tick;
    logic        last_tick;

    // A request and a grant on the same edge cancel out. The increment
    // saturates, so a request at the limit is dropped.
    function automatic logic [2:0] pend_next(input logic [2:0] cur,
                                             input logic       req,
                                             input logic       grant);
        if (req && !grant)
            return (cur == PEND_LIM) ? cur : cur + 3'd1;
        else if (grant && !req)
            return cur - 3'd1;
        else
            return cur;
    endfunction

    assign both_pending = (pend1 != 3'd0) && (pend2 != 3'd0);
    assign tick         = (state != IDLE) && (presc == 13'd0);
    assign last_tick    = tick && (timer == 10'd1);

    // Grant arbitration. The round-robin pointer only matters when both
    // valves are waiting. A lone requester is granted at once.
    always_comb begin
        grant1 = 1'b0;
        grant2 = 1'b0;
        if (state == IDLE && enable) begin
            if (both_pending) begin
                grant1 = !rr_ptr;
                grant2 = rr_ptr;
            end else if (pend1 != 3'd0) begin
                grant1 = 1'b1;
            end else if (pend2 != 3'd0) begin
                grant2 = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic. Dropping enable never cuts a sequence short; it only
    // stops the next grant out of IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant1 || grant2) state_next = FIRE;
            FIRE:    if (last_tick)        state_next = RECOVER;
            RECOVER: if (last_tick)        state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
    end

    // Prescaler, tick timer, valve drives and round-robin pointer. The
    // prescaler reloads on every tick, so each tick is exactly TICK_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= 13'd0;
            timer      <= 10'd0;
            valve1_cmd <= 1'b0;
            valve2_cmd <= 1'b0;
            rr_ptr     <= 1'b0;
        end else if (grant1 || grant2) begin
            presc      <= PRESC_LOAD;
            timer      <= PULSE_LOAD;
            valve1_cmd <= grant1;
            valve2_cmd <= grant2;
            if (both_pending)
                rr_ptr <= ~rr_ptr;
        end else if (state != IDLE) begin
            if (tick) begin
                presc <= PRESC_LOAD;
                if (timer == 10'd1) begin
                    valve1_cmd <= 1'b0;
                    valve2_cmd <= 1'b0;
                    timer      <= (state == FIRE) ? RECOVER_LOAD : 10'd0;
                end else begin
                    timer <= timer - 10'd1;
                end
            end else begin
                presc <= presc - 13'd1;
            end
        end
    end

    // Pending counters and the sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend1    <= 3'd0;
            pend2    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            pend1 <= pend_next(pend1, req1, grant1);
            pend2 <= pend_next(pend2, req2, grant2);
            if ((req1 && pend1 == PEND_LIM) || (req2 && pend2 == PEND_LIM))
                overflow <= 1'b1;
        end
    end

`ifdef VALVE_SCHED_STATS_EN
    // Per-valve firing statistics, wrapping at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_cnt1 <= 16'd0;
            fire_cnt2 <= 16'd0;
        end else begin
            if (grant1) fire_cnt1 <= fire_cnt1 + 16'd1;
            if (grant2) fire_cnt2 <= fire_cnt2 + 16'd1;
        end
    end
`else
    assign fire_cnt1 = 16'd0;
    assign fire_cnt2 = 16'd0;
`endif

endmodule

// File: doc/valve_air_sched.md
Name: valve_air_sched

Overview:
Schedules ejector valve firings on the sorting line so that only one valve draws from the shared compressed-air supply at a time. It accepts per-valve fire requests, which are single-cycle pulses from the valve timing logic, and queues them as saturating pending counts. It grants the air supply round-robin, drives the valve for a fixed pulse width, then enforces a pressure-recovery gap before the next grant. Timing uses a 100 us tick derived from the 50 MHz system clock.

Parameters:
TICK_DIV, 5000, clock cycles per tick (100 us at 50 MHz); legal range 2..8191.
PULSE_TICKS, 300, valve-open duration in ticks (30 ms); legal range 1..1023.
RECOVER_TICKS, 200, air-recovery gap after each pulse, in ticks; legal range 1..1023.
PEND_MAX, 7, saturation limit of each pending counter (3-bit).

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = grants allowed; 0 = no new grant (an in-progress pulse/recovery completes)
req1  in  1  fire request for valve 1, one count per cycle high
req2  in  1  fire request for valve 2, one count per cycle high
valve1_cmd  out  1  valve 1 drive, registered
valve2_cmd  out  1  valve 2 drive, registered
busy  out  1  high in FIRE or RECOVER
pend1  out  3  pending count, valve 1
pend2  out  3  pending count, valve 2
overflow  out  1  sticky; set when a request arrives while its counter equals PEND_MAX
fire_cnt1  out  16  valve 1 firings (see Optional Feature)
fire_cnt2  out  16  valve 2 firings (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; pending counters 0; prescaler and timer 0; round-robin pointer = valve 1 first.
- Pending update each edge: +1 on reqN; -1 on a grant to N; both in the same cycle leaves the count unchanged. Increment saturates at PEND_MAX and sets overflow. overflow clears only on reset.
- States:
  - IDLE: leaves when enable=1 and (pend1|pend2)!=0.
    - Only one nonzero: grant it.
    - Both nonzero: grant the valve the RR pointer names, then toggle the pointer to the other valve.
    - On the grant edge: state goes to FIRE, the granted valveN_cmd goes to 1, pending decrements, prescaler loads TICK_DIV-1, timer loads PULSE_TICKS.
  - FIRE: the prescaler counts down and issues a tick at 0, then reloads TICK_DIV-1. Each tick decrements the timer.
    - On the tick where the timer equals 1: valve_cmd goes to 0, state goes to RECOVER, prescaler reloads, timer loads RECOVER_TICKS.
    - valve_cmd is therefore high for exactly PULSE_TICKS*TICK_DIV cycles.
  - RECOVER: same countdown. On the final tick, return to IDLE. The gap is exactly RECOVER_TICKS*TICK_DIV cycles.
- Latency: a req sampled at edge k makes pend nonzero after k. With IDLE and enable=1, valve_cmd rises at edge k+1.
- At most one valve_cmd is high at any time. busy=1 in FIRE and RECOVER.
- enable going low mid-FIRE/RECOVER does not truncate the sequence; the scheduler parks in IDLE with pending counts held.
- Requests arriving during FIRE/RECOVER are counted and never lost, except at saturation.
- Reset mid-pulse drops valve_cmd immediately (async) and discards pending counts.

Optional Feature:
VALVE_SCHED_STATS_EN
- Defined: fire_cnt1/fire_cnt2 increment on each grant edge to that valve. They wrap 0xFFFF to 0 and reset to 0.
- Undefined: both ports are tied to 0 and no counter registers are built.

Test Plan:
- TICK_DIV=4, PULSE_TICKS=3, RECOVER_TICKS=2. Single req1 pulse -> valve1_cmd high 1 cycle later for exactly 12 cycles, then busy for 8 more cycles, then IDLE; pend1 returns to 0.
- req1 and req2 in the same cycle from reset -> valve1 fires first (12 cycles), 8-cycle gap, then valve2 fires. Valve cmds never overlap.
- Eight req1 pulses while enable=0 -> pend1=7 and overflow=1. Set enable=1 -> seven valve1 pulses, each separated by an 8-cycle gap.
- Repeated simultaneous req1+req2 -> grants alternate 1,2,1,2. A req1 arriving on the same edge as a valve1 grant leaves pend1 unchanged.
- rst_n asserted in the middle of a valve2 pulse -> valve2_cmd, busy and pend cleared with no clock edge required. First grant after reset goes to valve 1.
- With VALVE_SCHED_STATS_EN: after 3 valve1 and 2 valve2 firings -> fire_cnt1=3, fire_cnt2=2. Without the macro -> both read 0.
